// File: rtl/sqrt2_bus_master.sv
// sqrt2_bus_master: sequencer in front of the FP16 square-root unit.
// Operands arrive on a valid/ready stream and wait in a small FIFO. For each
// operand the master raises ENABLE, drives the shared IO_DATA bus for the
// load window, waits for RESULT (or times out), captures the word and flags,
// then holds ENABLE low for a gap so the unit re-arms.
//   CLK, RESET                 clock, synchronous active-high reset
//   IN_VALID/IN_READY/IN_DATA  operand stream (FP16)
//   OUT_VALID/OUT_READY        result stream
//   OUT_DATA, OUT_FLAGS        result word, flags {TIMEOUT, NINF, PINF, NAN}
//   SQ_IO_DATA                 shared tri-state bus to the unit
//   SQ_ENABLE, SQ_RESULT       unit handshake
//   SQ_IS_NAN/PINF/NINF        unit result flags
module sqrt2_bus_master #(
  parameter int FIFO_DEPTH   = 4,
  parameter int DRIVE_CYCLES = 2,
  parameter int TIMEOUT      = 32,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] OUT_DATA,
  output logic [3:0]  OUT_FLAGS,
  inout  wire  [15:0] SQ_IO_DATA,
  output logic        SQ_ENABLE,
  input  logic        SQ_RESULT,
  input  logic        SQ_IS_NAN,
  input  logic        SQ_IS_PINF,
  input  logic        SQ_IS_NINF
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + DRIVE_CYCLES + GAP_CYCLES + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_GAP} state_t;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   drive_q;
  logic          oe_q, en_q, out_valid_q;

  logic push, pop;

  assign IN_READY = ~RESET & (count < (AW+1)'(FIFO_DEPTH));
  assign push     = IN_VALID & IN_READY;
  // Launch only when nothing is held, so backpressure stalls instead of dropping.
  assign pop      = (state == S_IDLE) & (count != '0) & ~out_valid_q;

  // Reset can only switch the driver and ENABLE off, never on, so gating them
  // releases the bus in the reset cycle without creating a contention path.
  assign SQ_IO_DATA = (oe_q & ~RESET) ? drive_q : 16'hzzzz;
  assign SQ_ENABLE  = en_q & ~RESET;
  assign OUT_VALID  = out_valid_q & ~RESET;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= IN_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_GAP;
      cnt         <= CW'(GAP_CYCLES);
      drive_q     <= '0;
      oe_q        <= 1'b0;
      en_q        <= 1'b0;
      out_valid_q <= 1'b0;
      OUT_DATA    <= '0;
      OUT_FLAGS   <= '0;
    end else begin
      // A capture below overrides this clear when both happen together.
      if (out_valid_q && OUT_READY) out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            drive_q <= fifo_mem[rd_ptr];
            state   <= S_DRIVE;
            cnt     <= '0;
            oe_q    <= 1'b1;
            en_q    <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt == CW'(DRIVE_CYCLES - 1)) begin
            state <= S_WAIT;
            cnt   <= '0;
            oe_q  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (SQ_RESULT) begin
            OUT_DATA    <= SQ_IO_DATA;
            OUT_FLAGS   <= {1'b0, SQ_IS_NINF, SQ_IS_PINF, SQ_IS_NAN};
            out_valid_q <= 1'b1;
            state       <= S_GAP;
            cnt         <= CW'(GAP_CYCLES);
            en_q        <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            OUT_DATA    <= 16'h7E00;
            OUT_FLAGS   <= 4'b1001;
            out_valid_q <= 1'b1;
            state       <= S_GAP;
            cnt         <= CW'(GAP_CYCLES);
            en_q        <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt <= CW'(1)) state <= S_IDLE;
          else               cnt   <= cnt - 1'b1;
        end
        default: begin
          state <= S_GAP;
          cnt   <= CW'(GAP_CYCLES);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt2_bus_master.sv
module tb_sqrt2_bus_master;

  localparam int DRIVE_CYCLES = 2;
  localparam int TIMEOUT      = 32;

  logic        CLK = 1'b0;
  logic        RESET, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [15:0] IN_DATA, OUT_DATA;
  logic [3:0]  OUT_FLAGS;
  wire  [15:0] SQ_IO_DATA;
  logic        SQ_ENABLE, SQ_RESULT, SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sqrt2_bus_master #(.FIFO_DEPTH(4), .DRIVE_CYCLES(DRIVE_CYCLES), .TIMEOUT(TIMEOUT), .GAP_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_FLAGS(OUT_FLAGS),
    .SQ_IO_DATA(SQ_IO_DATA), .SQ_ENABLE(SQ_ENABLE), .SQ_RESULT(SQ_RESULT),
    .SQ_IS_NAN(SQ_IS_NAN), .SQ_IS_PINF(SQ_IS_PINF), .SQ_IS_NINF(SQ_IS_NINF)
  );

  // Behavioural unit: latches the operand on the first ENABLE cycle, answers a
  // few cycles later from a table; operands not in the table never answer.
  function automatic logic [19:0] unit_lut(input logic [15:0] op);
    case (op)
      16'h1234: return {1'b1, 3'b000, 16'h270B};
      16'h6066: return {1'b1, 3'b000, 16'h4DEE};
      16'h10C7: return {1'b1, 3'b000, 16'h262E};
      16'h0016: return {1'b1, 3'b000, 16'h14B0};
      16'h002C: return {1'b1, 3'b000, 16'h16A2};
      16'hFC00: return {1'b1, 3'b001, 16'hFE00};
      16'h7D00: return {1'b1, 3'b001, 16'h7F00};
      16'h7C00: return {1'b1, 3'b010, 16'h7C00};
      16'h8000: return {1'b1, 3'b000, 16'h8000};
      16'h0000: return {1'b1, 3'b000, 16'h0000};
      default:  return '0;
    endcase
  endfunction

  logic [7:0]  ecnt = '0;
  logic [15:0] m_op = '0, m_word = '0;
  logic [2:0]  m_flags = '0;
  logic        m_drv = 1'b0;
  logic [19:0] lut_v;

  assign lut_v      = unit_lut(m_op);
  assign SQ_IO_DATA = m_drv ? m_word : 16'hzzzz;
  assign SQ_RESULT  = m_drv;
  assign SQ_IS_NAN  = m_drv & m_flags[0];
  assign SQ_IS_PINF = m_drv & m_flags[1];
  assign SQ_IS_NINF = m_drv & m_flags[2];

  always @(posedge CLK) begin
    if (!SQ_ENABLE) begin
      ecnt  <= '0;
      m_drv <= 1'b0;
    end else begin
      ecnt <= ecnt + 1'b1;
      if (ecnt == 8'd0) m_op <= SQ_IO_DATA;
      if (ecnt == 8'd3 && lut_v[19]) begin
        m_drv   <= 1'b1;
        m_word  <= lut_v[15:0];
        m_flags <= lut_v[18:16];
      end
    end
  end

  typedef struct {
    logic [15:0] op;
    logic [15:0] data;
    logic [3:0]  flags;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // Protocol monitor and scoreboard.
  int          en_len = 0, low_len = 100, drv_cnt = 0, last_en_len = 0;
  logic        prev_en = 1'b0, prev_ov = 1'b0, prev_rdy = 1'b0;
  logic [15:0] prev_data = '0;
  logic [3:0]  prev_flags = '0;

  always @(negedge CLK) begin
    bit   bz;
    exp_t e;
    bz = (SQ_IO_DATA === 16'hzzzz);
    if (SQ_ENABLE) begin
      if (!prev_en) begin
        chk("enable_gap", 32'(low_len >= 2), 1);
        chk("launch_while_held", OUT_VALID, 0);
        en_len  = 0;
        drv_cnt = 0;
      end
      en_len++;
      if (!bz && !m_drv) begin
        drv_cnt++;
        if (sb.size() > 0) chk("bus_operand", SQ_IO_DATA, sb[0].op);
      end
    end else begin
      if (prev_en && !RESET) begin
        chk("drive_cycles", drv_cnt, DRIVE_CYCLES);
        last_en_len = en_len;
      end
      if (!m_drv) chk("bus_z_enable_low", bz, 1);
      low_len++;
      if (prev_en) low_len = 1;
    end
    prev_en = SQ_ENABLE;
    if (!RESET) begin
      if (OUT_VALID && prev_ov && !prev_rdy) begin
        chk("hold_data", OUT_DATA, prev_data);
        chk("hold_flags", OUT_FLAGS, prev_flags);
      end
      if (OUT_VALID && OUT_READY) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL spurious_result: observed %0h expected none", OUT_DATA);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result_data", OUT_DATA, e.data);
          chk("result_flags", OUT_FLAGS, e.flags);
          if (e.flags[3]) chk("timeout_len", last_en_len, DRIVE_CYCLES + TIMEOUT);
        end
      end
      prev_ov    = OUT_VALID;
      prev_rdy   = OUT_READY;
      prev_data  = OUT_DATA;
      prev_flags = OUT_FLAGS;
    end
  end

  task automatic push(input logic [15:0] op, input logic [15:0] d, input logic [3:0] f);
    int   n = 0;
    exp_t e;
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_DATA  = op;
    e.op = op; e.data = d; e.flags = f;
    sb.push_back(e);
    while (!IN_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("push_timeout", 32'(n < 200), 1);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (6) @(negedge CLK);
  endtask

  initial begin
    int n;
    RESET = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_out_flags", OUT_FLAGS, 0);
    chk("rst_enable", SQ_ENABLE, 0);
    chk("rst_bus_z", 32'(SQ_IO_DATA === 16'hzzzz), 1);
    RESET = 1'b0;
    #1 chk("post_rst_in_ready", IN_READY, 1);
    repeat (4) @(negedge CLK);

    // Single operand.
    push(16'h1234, 16'h270B, 4'b0000);
    drain(200);

    // Back-to-back burst: first operand launches before the fourth push.
    push(16'h6066, 16'h4DEE, 4'b0000);
    push(16'h10C7, 16'h262E, 4'b0000);
    push(16'h0016, 16'h14B0, 4'b0000);
    push(16'h002C, 16'h16A2, 4'b0000);
    chk("burst_in_ready", IN_READY, 1);
    drain(400);

    // Special values.
    push(16'hFC00, 16'hFE00, 4'b0001);
    push(16'h7D00, 16'h7F00, 4'b0001);
    push(16'h7C00, 16'h7C00, 4'b0010);
    push(16'h8000, 16'h8000, 4'b0000);
    drain(400);

    // Timeout then a normal operand.
    push(16'h3C00, 16'h7E00, 4'b1001);
    push(16'h1234, 16'h270B, 4'b0000);
    drain(400);

    // Backpressure: one result held, nothing else launches.
    OUT_READY = 1'b0;
    push(16'h1234, 16'h270B, 4'b0000);
    push(16'h6066, 16'h4DEE, 4'b0000);
    push(16'h10C7, 16'h262E, 4'b0000);
    repeat (20) @(negedge CLK);
    chk("bp_held_valid", OUT_VALID, 1);
    chk("bp_held_data", OUT_DATA, 16'h270B);
    chk("bp_pending", sb.size(), 3);
    OUT_READY = 1'b1;
    drain(400);

    // Reset while waiting on a silent unit, with operands queued behind it.
    push(16'h3C00, 16'h7E00, 4'b1001);
    n = 0;
    while (!SQ_ENABLE && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_test_launch", SQ_ENABLE, 1);
    repeat (4) @(negedge CLK);
    push(16'h1234, 16'h270B, 4'b0000);
    push(16'h6066, 16'h4DEE, 4'b0000);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_enable", SQ_ENABLE, 0);
    chk("mid_rst_bus_z", 32'(SQ_IO_DATA === 16'hzzzz), 1);
    chk("mid_rst_out_valid", OUT_VALID, 0);
    chk("mid_rst_in_ready", IN_READY, 0);
    sb.delete();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1 chk("post_mid_rst_in_ready", IN_READY, 1);
    push(16'h0000, 16'h0000, 4'b0000);
    drain(200);
    repeat (60) @(negedge CLK);
    chk("no_stale_results", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
